// File: rtl/fir_out_stage.sv
// fir_out_stage: round, saturate and decimate FIR results into a show-ahead FIFO; FIR_OUT_CONVERGENT_EN selects round-half-to-even
module fir_out_stage #(
  parameter int IN_WIDTH   = 37,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_SHIFT = 15,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_WIDTH-1:0]           y_in,
  input  logic                          y_valid,
  output logic signed [OUT_WIDTH-1:0]   d_out,
  output logic                          d_valid,
  input  logic                          d_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          sat_flag,
  output logic                          ovf_flag,
  input  logic                          clr_flags
);
  localparam int RW = IN_WIDTH + 1 - FRAC_SHIFT;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [IN_WIDTH:0] HALF = (IN_WIDTH+1)'(1) << (FRAC_SHIFT - 1);
  logic signed [IN_WIDTH:0] sum;
  logic tie;
  logic [RW-1:0] r, s1_r;
  logic s1_v, s2_v, sat, keep, full, push, pop;
  logic [OUT_WIDTH-1:0] clamp, s2_d;
  logic [3:0] dcnt;
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_n;
  logic [CW-1:0] cnt_n;
  // rounding: add half an LSB in a one-bit-wider sum, then drop the fraction; a tie is forced even when convergent
  always_comb begin
    sum = $signed({y_in[IN_WIDTH-1], y_in} + HALF);
`ifdef FIR_OUT_CONVERGENT_EN
    tie = y_in[FRAC_SHIFT-1:0] == HALF[FRAC_SHIFT-1:0];
`else
    tie = 1'b0;
`endif
    r = RW'(sum >>> FRAC_SHIFT) & ~RW'(tie);
  end
  // clamp, decimation keep decision and FIFO push/pop bookkeeping
  always_comb begin
    sat = !(&s1_r[RW-1:OUT_WIDTH-1]) && |s1_r[RW-1:OUT_WIDTH-1];
    clamp = sat ? {s1_r[RW-1], {(OUT_WIDTH-1){~s1_r[RW-1]}}} : s1_r[OUT_WIDTH-1:0];
    keep = s1_v && dcnt == '0;
    d_valid = fifo_count != '0;
    pop = d_valid && d_ready;
    full = fifo_count == CW'(FIFO_DEPTH);
    push = s2_v && (!full || pop);
    cnt_n = fifo_count + CW'(push) - CW'(pop);
    rptr_n = rptr + AW'(pop);
  end
  // two-stage pipeline, decimation counter and saturation flag
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_r <= '0;
      s2_v <= 1'b0;
      s2_d <= '0;
      dcnt <= '0;
      sat_flag <= 1'b0;
    end else begin
      s1_v <= y_valid;
      s1_r <= r;
      s2_v <= keep;
      s2_d <= clamp;
      dcnt <= s1_v ? (dcnt == 4'(DECIM - 1) ? '0 : dcnt + 4'd1) : dcnt;
      sat_flag <= (keep && sat) || (sat_flag && !clr_flags);
    end
  end
  // FIFO pointers, occupancy, registered head sample and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      fifo_count <= '0;
      d_out <= '0;
      ovf_flag <= 1'b0;
    end else begin
      wptr <= wptr + AW'(push);
      rptr <= rptr_n;
      fifo_count <= cnt_n;
      d_out <= cnt_n != '0 ? ((push && rptr_n == wptr) ? s2_d : mem[rptr_n]) : d_out;
      ovf_flag <= (s2_v && full && !pop) || (ovf_flag && !clr_flags);
    end
  end
  // sample storage
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= s2_d;
  end
endmodule

// File: doc/fir_out_stage.md
# fir_out_stage

Output formatter that sits directly downstream of the serial FIR filter. It takes the filter's wide accumulator result (`y_in`/`y_valid`), rounds away the coefficient fraction bits, saturates to the system sample width, and optionally decimates. Results are buffered in a small FIFO and delivered through a valid/ready handshake to the sink (DAC interface or capture logic). Sticky flags report saturation and FIFO-overflow events to software.

## Interface
- `IN_WIDTH`, 37, width of the FIR accumulator input (signed).
- `OUT_WIDTH`, 16, output sample width (signed).
- `FRAC_SHIFT`, 15, fraction bits removed by rounding (Q15 coefficients); range 1..IN_WIDTH-OUT_WIDTH.
- `DECIM`, 1, decimation factor; range 1..16.
- `FIFO_DEPTH`, 8, output FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `y_in`  in  IN_WIDTH  signed filter result.
- `y_valid`  in  1  `y_in` qualifier; no backpressure to the filter.
- `d_out`  out  OUT_WIDTH  signed FIFO head sample.
- `d_valid`  out  1  FIFO non-empty.
- `d_ready`  in  1  sink accepts `d_out` this cycle.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `sat_flag`  out  1  sticky: a kept sample was clamped.
- `ovf_flag`  out  1  sticky: a sample was dropped on a full FIFO.
- `clr_flags`  in  1  synchronous clear of both sticky flags.

## Operation
- Stage 1 (round): `sum = y_in + 2^(FRAC_SHIFT-1)`, computed in IN_WIDTH+1 bits so it cannot overflow; `r = sum >>> FRAC_SHIFT` (arithmetic shift). Registered together with a valid bit.
- Stage 2 (saturate and decimate): clamp `r` to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. The decimation counter runs 0..DECIM-1 and advances once per stage-1 valid. A sample is kept only when the counter is 0, so the first sample after reset is always kept. Saturation on a kept sample sets `sat_flag`; saturation on a discarded sample does not.
- FIFO: a kept sample is written on the next edge. Writing when full drops the sample, leaves the contents unchanged, and sets `ovf_flag`. If full and `d_valid && d_ready` occur in the same cycle, the pop frees the slot and the write is accepted with no drop.
- Read side is show-ahead: `d_out` is the head entry whenever `d_valid`=1. An entry pops on an edge where `d_valid && d_ready`. `d_out` holds its last value when empty.
- Flags: `clr_flags` clears both flags. If a set event and `clr_flags` occur in the same cycle, the set wins.
- No state machine beyond the pipeline valids, the decimation counter and the FIFO pointers. Pointers wrap modulo FIFO_DEPTH; full/empty are derived from `fifo_count`.

## Timing
- Reset (any cycle, including mid-burst): pipeline valids = 0, decimation counter = 0, FIFO emptied, `d_valid`=0, `d_out`=0, `fifo_count`=0, `sat_flag`=0, `ovf_flag`=0. Any in-flight samples are discarded.
- Latency: `y_valid` sampled at edge k → stage 1 registered at k, stage 2 at k+1, FIFO write at k+2 → `d_valid`=1 after edge k+2 when the FIFO was empty.
- Throughput: one input per cycle, sustained, while `d_ready`=1 and DECIM=1.
- `fifo_count` updates on the same edge as the push/pop; simultaneous push and pop leaves it unchanged.

## Configuration
- `FIR_OUT_CONVERGENT_EN`:
  - Defined: stage 1 uses round-half-to-even. On an exact tie (low FRAC_SHIFT bits = 100…0), the result rounds to the even neighbour. Latency is unchanged.
  - Undefined: round-half-up, as described in Operation.

## Test plan
- Rounding, FRAC_SHIFT=15: `y_in` = 16384, 49152, 16383, -16385 → `d_out` = 1, 2, 0, -1. With `FIR_OUT_CONVERGENT_EN`: → 0, 2, 0, -1.
- Saturation: `y_in` = 2^36-1 → 32767 and `sat_flag`=1. Then pulse `clr_flags`, then `y_in` = -2^36 → -32768 and `sat_flag`=1 again.
- Decimation, DECIM=4: 12 back-to-back inputs `y_in` = n·32768, n = 0..11 → exactly 3 outputs: 0, 4, 8.
- Backpressure/overflow: `d_ready`=0, 10 inputs 1..10 (×32768) → `fifo_count`=8 and `ovf_flag`=1. Then `d_ready`=1 → outputs 1..8 in order, then `d_valid`=0.
- Full with simultaneous pop: FIFO holds 8 entries, `d_ready`=1, one new input arriving at the FIFO on the pop edge → no drop, `fifo_count` stays 8, `ovf_flag` stays 0.
- Reset mid-burst: assert `rst` for one cycle during continuous input with 3 entries queued → after that edge `d_valid`=0 and `fifo_count`=0. Next input appears 3 edges after its `y_valid`.
